// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Purpose  : Shared types and constants for the nibble-serial add/sub path.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  // Sequencer states; encoding is fixed so it reads the same in waveforms.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Number of nibble passes needed for an operand of the given width.
  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fourBitAdder.sv
`default_nettype none
// ============================================================================
// Module   : fourBitAdder
// Purpose  : 4-bit ripple-carry adder, shared across nibble passes.
// Revision : 1.0 - initial release
// ============================================================================
module fourBitAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] w_carry;

  assign w_carry[0] = Cin;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]         = A[i] ^ B[i] ^ w_carry[i];
    assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_carry[4];

endmodule
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_ctrl
// Purpose  : Multi-cycle add/subtract, one nibble per cycle through a single
//            shared 4-bit adder, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  import addsub_pkg::*;

  localparam int            N    = nibbles(WIDTH);
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;     // holds b_eff (already inverted for sub)
  logic [WIDTH-1:0] res_q,   res_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             zero_q,  zero_d;

  logic [NIBBLE_W-1:0] w_nib_a, w_nib_b, w_sum;
  logic                w_cout;
  int                  w_base;

  // Nibble mux feeding the shared adder.
  assign w_base  = int'(cnt_q) * NIBBLE_W;
  assign w_nib_a = a_q[w_base +: NIBBLE_W];
  assign w_nib_b = b_q[w_base +: NIBBLE_W];

  fourBitAdder u_adder (
    .A    (w_nib_a),
    .B    (w_nib_b),
    .Cin  (carry_q),
    .S    (w_sum),
    .Cout (w_cout)
  );

  // State register and datapath registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state, operand latching, result demux and flag capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;            // +1 completes the two's-complement of b
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[w_base +: NIBBLE_W] = w_sum;
        carry_d = w_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Flags are captured from the completed result on the final pass,
          // so they stay frozen for the whole DONE phase.
          cnt_d   = '0;
          state_d = DONE;
          cout_d  = w_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (res_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = ~|res_d;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = res_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub_ctrl
// Purpose  : Directed self-checking bench for serial_addsub_ctrl (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int ncnt  = 0;
  int acc_q[$];

  serial_addsub_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Record the negedge index preceding every accepting posedge.
  always @(negedge clk) begin
    ncnt <= ncnt + 1;
    if (!rst && start_valid && start_ready) acc_q.push_back(ncnt);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic vs);
    a = va; b = vb; sub = vs; start_valid = 1'b1;
    check_eq("start_ready_idle", 32'(start_ready), 32'd1);
    tick;
    start_valid = 1'b0;
  endtask

  // Returns the cycle number (accept = 0) at which res_valid is first seen.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!res_valid && cyc < 40) begin
      tick;
      cyc++;
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] r,
                           input logic co, input logic ov, input logic z);
    check_eq({tag, "_result"}, result, r);
    check_eq({tag, "_cout"}, 32'(cout), 32'(co));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(ov));
    check_eq({tag, "_zero"}, 32'(zero), 32'(z));
  endtask

  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vs, input logic [31:0] r,
                        input logic co, input logic ov, input logic z);
    int cyc;
    launch(va, vb, vs);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(cyc);
    check_eq({tag, "_latency"}, cyc, 32'd9);
    check_res(tag, r, co, ov, z);
    check_eq({tag, "_sr_in_done"}, 32'(start_ready), 32'd0);
    tick;
    check_eq({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int  cyc;
    int  c;
    int  diff;
    logic seen;

    rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; sub = 1'b0; res_ready = 1'b1;
    #12;
    check_eq("rst_start_ready", 32'(start_ready), 32'd1);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    tick;

    // Additions and subtractions with hand-computed results.
    run_op("add_5_3",   32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_min",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_7_7",   32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Reset in RUN cycle 4: three nibbles of 0xFFE already written.
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (3) tick;
    #2 rst = 1'b1;
    #1;
    check_eq("abort_start_ready", 32'(start_ready), 32'd1);
    check_eq("abort_res_valid", 32'(res_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_res("abort", 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick;
      if (res_valid) seen = 1'b1;
    end
    check_eq("abort_no_valid", 32'(seen), 32'd0);
    run_op("post_rst",  32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // Backpressure with operand churn during RUN and DONE.
    res_ready = 1'b0;
    launch(32'hA5A5_0000, 32'h0000_0001, 1'b1);
    seen = 1'b0;
    cyc  = 1;
    while (!res_valid && cyc < 40) begin
      a = $urandom; b = $urandom; sub = ~sub;
      if (start_ready) seen = 1'b1;
      tick;
      cyc++;
    end
    check_eq("bp_latency", cyc, 32'd9);
    check_eq("bp_sr_in_run", 32'(seen), 32'd0);
    repeat (5) begin
      check_res("bp_hold", 32'hA5A4_FFFF, 1'b1, 1'b0, 1'b0);
      check_eq("bp_sr_in_done", 32'(start_ready), 32'd0);
      check_eq("bp_valid_held", 32'(res_valid), 32'd1);
      a = $urandom; b = $urandom; sub = ~sub;
      tick;
    end
    res_ready = 1'b1;
    tick;
    check_eq("bp_release_valid", 32'(res_valid), 32'd0);
    check_eq("bp_release_sr", 32'(start_ready), 32'd1);

    // Back-to-back issue with start_valid held high.
    acc_q.delete();
    a = 32'h0000_00FF; b = 32'h0000_0001; sub = 1'b0; start_valid = 1'b1;
    tick;
    a = 32'h0000_0010; b = 32'h0000_0020; sub = 1'b1;
    wait_valid(cyc);
    check_eq("b2b_first_latency", cyc, 32'd9);
    check_res("b2b_first", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    c = 0;
    while (!start_ready && c < 20) begin
      tick;
      c++;
    end
    tick;
    start_valid = 1'b0;
    diff = (acc_q.size() == 2) ? (acc_q[1] - acc_q[0]) : -1;
    check_eq("b2b_accepts", acc_q.size(), 32'd2);
    check_eq("b2b_interval", diff, 32'd10);
    wait_valid(cyc);
    check_eq("b2b_second_latency", cyc, 32'd9);
    check_res("b2b_second", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Multi-cycle add/subtract sequencer that produces a WIDTH-bit sum or difference by time-sharing one 4-bit ripple adder (`fourBitAdder`) across WIDTH/4 nibble passes. It sits in the AddSub slice of the 32-bit ALU as the area-optimised add/sub path. It accepts operands through a valid/ready handshake, keeps the carry between passes, assembles the result LSB-nibble first, and returns result plus flags through a second valid/ready handshake.

## Interface
- `WIDTH`, default 32: operand/result width. Must be a multiple of 4 and at least 8.
- `clk` in 1: the single clock. Every state element updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start_valid` in 1: operands and op are valid.
- `start_ready` out 1: block can accept; high only in IDLE.
- `a` in WIDTH: operand A, sampled on the accept edge.
- `b` in WIDTH: operand B, sampled on the accept edge.
- `sub` in 1: 0 = A+B, 1 = A−B. Sampled on the accept edge.
- `res_valid` out 1: result and flags are valid.
- `res_ready` in 1: consumer takes the result.
- `result` out WIDTH: sum or difference, modulo 2^WIDTH.
- `cout` out 1: carry out of the MSB nibble. For sub this is not-borrow (1 iff A ≥ B unsigned).
- `ovf` out 1: two's-complement signed overflow.
- `zero` out 1: result == 0.
- `busy` out 1: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** `start_ready`=1. On `start_valid`&`start_ready`:
  - latch `a` and `b_eff` = `sub` ? ~`b` : `b`.
  - set carry register = `sub`, nibble counter = 0, go to RUN.
- **RUN**, each cycle:
  - Adder inputs: A nibble[cnt], b_eff nibble[cnt], carry register.
  - Sum is written into result nibble[cnt]; carry register ← adder Cout; cnt++.
  - After nibble N−1 (N = WIDTH/4) go to DONE.
- **DONE:** `res_valid`=1.
  - `cout` = final carry.
  - `ovf` = (A[MSB] == b_eff[MSB]) && (result[MSB] != A[MSB]).
  - `zero` = ~|result.
  - On `res_ready` go to IDLE.
  - No new operation is accepted in the same cycle (`start_ready`=0 in DONE).
- Changes to `a`, `b` or `sub` after the accept edge have no effect.
- `result` and flags hold stable for as long as `res_valid` is high.
- Reset values: state=IDLE, `start_ready`=1, `res_valid`=0, `busy`=0, `result`=0, `cout`=0, `ovf`=0, `zero`=0, counter=0, carry=0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. The aborted operation produces no `res_valid`.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..N. `res_valid` rises at the start of cycle N+1 (cycle 9 for WIDTH=32).
- Minimum issue interval is N+2 cycles (10 for WIDTH=32).
- Flags are registered, not combinational from live inputs.
- `start_ready` and `res_valid` are never high together.
- `start_valid` held high while busy is ignored until IDLE; it is accepted on the first IDLE cycle.
- Holding `res_ready` low stalls the block in DONE indefinitely.

## Structure
- Shared package `addsub_pkg` holds:
  - state enum (IDLE=0, RUN=1, DONE=2);
  - `NIBBLE_W` = 4;
  - function `nibbles(WIDTH)` = WIDTH/4.
- One sub-module: the existing `fourBitAdder` (ports A, B, Cin, S, Cout), instantiated once.
- All sequencing, operand latching, nibble mux/demux and flag logic live in `serial_addsub_ctrl`.

## Test plan
All scenarios use WIDTH=32.
1. Add 0x0000_0005 + 0x0000_0003 → `result`=0x0000_0008, `cout`=0, `ovf`=0, `zero`=0, `res_valid` first high in cycle 9.
2. Add 0xFFFF_FFFF + 0x0000_0001 → `result`=0, `cout`=1, `zero`=1, `ovf`=0. Add 0x7FFF_FFFF + 1 → `result`=0x8000_0000, `ovf`=1, `cout`=0.
3. Subtract:
   - 5 − 7 → `result`=0xFFFF_FFFE, `cout`=0, `ovf`=0.
   - 7 − 7 → `result`=0, `cout`=1, `zero`=1.
   - 0x8000_0000 − 1 → 0x7FFF_FFFF, `ovf`=1.
4. Backpressure: hold `res_ready` low 5 cycles and toggle `a`/`b` during RUN and DONE → `result` and flags unchanged, `start_ready`=0 throughout. Completes one cycle after `res_ready` rises.
5. Back-to-back: `start_valid` held high with two operand sets → second accept occurs exactly 10 cycles after the first, given `res_ready`=1.
6. Reset in RUN cycle 4 → all outputs at reset values asynchronously, no `res_valid`. A following add of 0x1234_5678 + 0x1111_1111 → 0x2345_6789.
